// File: rtl/or_reduce_pipe_pkg.sv
// Shared sizing helpers and types for the pipelined OR-reduction tree.
// All stage geometry is derived here so the top and its stages stay in agreement.
package or_reduce_pipe_pkg;

  typedef enum logic [1:0] {
    STK_HOLD,
    STK_CLEAR,
    STK_LOAD,
    STK_ACCUM
  } sticky_op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A one-bit input still needs one register stage.
  function automatic int num_st(input int width, input int lps);
    int d;
    d = clog2(width);
    return (d == 0) ? 1 : (d + lps - 1) / lps;
  endfunction

  // The last stage absorbs whatever levels remain, which may be fewer than lps.
  function automatic int st_levels(input int width, input int lps, input int k);
    int rem;
    rem = clog2(width) - k * lps;
    if (rem < 0) rem = 0;
    if (rem > lps) rem = lps;
    return rem;
  endfunction

  function automatic int st_in_w(input int width, input int lps, input int k);
    return (1 << clog2(width)) >> (k * lps);
  endfunction

  // Bit offset of stage k's input inside the flattened inter-stage data chain.
  function automatic int chain_off(input int width, input int lps, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) off += st_in_w(width, lps, i);
    return off;
  endfunction

endpackage

// File: rtl/or_reduce_stage.sv
// One pipeline stage: LEVELS of pairwise OR followed by a data/valid register.
// IN_W is always a power of two, so every level halves the vector exactly.
module or_reduce_stage #(
  parameter int IN_W   = 4,
  parameter int LEVELS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         next_adv,
  output logic                         adv,
  output logic                         out_valid,
  output logic [(IN_W>>LEVELS)-1:0]    out_data
);

  localparam int OUT_W = IN_W >> LEVELS;
  // Every level is packed end to end: level l starts at 2*IN_W - 2*(IN_W >> l).
  localparam int TOT_W = 2 * IN_W - OUT_W;

  wire [TOT_W-1:0] tree;
  logic            valid_reg;
  logic [OUT_W-1:0] data_reg;

  assign tree[IN_W-1:0] = in_data;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
      localparam int SRC = 2 * IN_W - 2 * (IN_W >> (gi - 1));
      localparam int DST = 2 * IN_W - 2 * (IN_W >> gi);
      for (gj = 0; gj < (IN_W >> gi); gj++) begin : g_node
        assign tree[DST+gj] = tree[SRC+2*gj] | tree[SRC+2*gj+1];
      end
    end
  endgenerate

  assign adv = ~valid_reg | next_adv;

  // Bubbles advance as valid=0 but leave the last result in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (adv) begin
      valid_reg <= in_valid;
      if (in_valid) data_reg <= tree[TOT_W-1 -: OUT_W];
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/or_reduce_pipe.sv
// Pipelined OR-reduction of a WIDTH-bit vector with valid/ready handshake
// and a sticky any-set flag accumulated over delivered results.
module or_reduce_pipe
  import or_reduce_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LVL_PER_ST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_any,
  output logic             out_zero,
  output logic             sticky,
  input  logic             sticky_clr
);

  localparam int PAD_W   = 1 << clog2(WIDTH);
  localparam int NUM_ST  = num_st(WIDTH, LVL_PER_ST);
  localparam int CHAIN_W = chain_off(WIDTH, LVL_PER_ST, NUM_ST) + 1;

  // chain holds each stage's input slice back to back; the final bit is the result.
  wire [CHAIN_W-1:0] chain;
  wire [NUM_ST:0]    st_valid;
  wire [NUM_ST:0]    st_adv;

  logic       deliver;
  logic       sticky_reg;
  sticky_op_e sticky_op;

  assign chain[PAD_W-1:0] = PAD_W'(in_data);
  assign st_valid[0]      = in_valid;
  assign st_adv[NUM_ST]   = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ST; gi++) begin : g_st
      localparam int IW   = st_in_w(WIDTH, LVL_PER_ST, gi);
      localparam int LV   = st_levels(WIDTH, LVL_PER_ST, gi);
      localparam int OW   = IW >> LV;
      localparam int IOFF = chain_off(WIDTH, LVL_PER_ST, gi);
      localparam int OOFF = IOFF + IW;

      or_reduce_stage #(
        .IN_W   (IW),
        .LEVELS (LV)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (st_valid[gi]),
        .in_data   (chain[IOFF +: IW]),
        .next_adv  (st_adv[gi+1]),
        .adv       (st_adv[gi]),
        .out_valid (st_valid[gi+1]),
        .out_data  (chain[OOFF +: OW])
      );
    end
  endgenerate

  assign in_ready  = st_adv[0];
  assign out_valid = st_valid[NUM_ST];
  assign out_any   = chain[CHAIN_W-1];
  assign out_zero  = ~out_any;
  assign deliver   = out_valid & out_ready;

  // A beat delivered on the clearing edge survives the clear.
  always_comb begin
    sticky_op = STK_HOLD;
    if (sticky_clr && deliver) sticky_op = STK_LOAD;
    else if (sticky_clr)       sticky_op = STK_CLEAR;
    else if (deliver)          sticky_op = STK_ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else begin
      case (sticky_op)
        STK_CLEAR: sticky_reg <= 1'b0;
        STK_LOAD:  sticky_reg <= out_any;
        STK_ACCUM: sticky_reg <= sticky_reg | out_any;
        default:   sticky_reg <= sticky_reg;
      endcase
    end
  end

  assign sticky = sticky_reg;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Self-checking bench: dut0 is W=32/LPS=2 (L=3), dut1 is W=7/LPS=1 (L=3).
module tb_or_reduce_pipe;

  localparam int L0 = 3;
  localparam int L1 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv [2];
  logic        ordy [2];
  logic        sclr [2];
  logic [31:0] d0;
  logic [6:0]  d1;
  logic        ir [2];
  logic        ov [2];
  logic        oa [2];
  logic        oz [2];
  logic        st [2];

  always #5 clk = ~clk;

  or_reduce_pipe #(.WIDTH(32), .LVL_PER_ST(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(d0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_any(oa[0]), .out_zero(oz[0]),
    .sticky(st[0]), .sticky_clr(sclr[0])
  );

  or_reduce_pipe #(.WIDTH(7), .LVL_PER_ST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(d1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_any(oa[1]), .out_zero(oz[1]),
    .sticky(st[1]), .sticky_clr(sclr[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model: L slots per DUT (slot 0 nearest the input).
  bit mv [2][8];
  bit ma [2][8];
  bit ms [2];
  bit prev_stall [2];
  bit prev_any [2];
  int acc [2];
  bit sb0 [$];
  bit sb1 [$];
  int logc0 [$];
  bit loga0 [$];
  int logc1 [$];
  bit loga1 [$];
  bit logz1 [$];

  function automatic int lat(input int m);
    return (m == 0) ? L0 : L1;
  endfunction

  function automatic bit din_any(input int m);
    return (m == 0) ? (d0 != 32'd0) : (d1 != 7'd0);
  endfunction

  function automatic bit m_in_ready(input int m);
    bit a;
    a = ordy[m];
    for (int k = lat(m) - 1; k >= 0; k--) a = !mv[m][k] || a;
    return a;
  endfunction

  task automatic chk(input string name, input int m, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", name, m, cyc, got, exp);
    end
  endtask

  task automatic model_clear(input int m);
    for (int k = 0; k < 8; k++) begin
      mv[m][k] = 1'b0;
      ma[m][k] = 1'b0;
    end
    ms[m] = 1'b0;
    prev_stall[m] = 1'b0;
    if (m == 0) sb0.delete(); else sb1.delete();
  endtask

  task automatic model_step(input int m);
    int n;
    bit adv [9];
    bit dlv;
    bit nv;
    bit na;
    n = lat(m);
    adv[n] = ordy[m];
    for (int k = n - 1; k >= 0; k--) adv[k] = !mv[m][k] || adv[k+1];
    dlv = mv[m][n-1] && ordy[m];
    if (sclr[m] && dlv)  ms[m] = ma[m][n-1];
    else if (sclr[m])    ms[m] = 1'b0;
    else if (dlv)        ms[m] = ms[m] | ma[m][n-1];
    if (iv[m] && adv[0]) begin
      if (m == 0) sb0.push_back(din_any(0)); else sb1.push_back(din_any(1));
    end
    for (int k = n - 1; k >= 0; k--) begin
      if (adv[k]) begin
        nv = (k == 0) ? iv[m] : mv[m][k-1];
        na = (k == 0) ? din_any(m) : ma[m][k-1];
        mv[m][k] = nv;
        if (nv) ma[m][k] = na;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: every falling edge checks both DUTs, then advances the model.
  initial forever begin
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        chk("rst_out_valid", m, ov[m], 1'b0);
        chk("rst_out_zero", m, oz[m], 1'b1);
        chk("rst_out_any", m, oa[m], 1'b0);
        chk("rst_sticky", m, st[m], 1'b0);
        model_clear(m);
      end else begin
        if (prev_stall[m]) begin
          chk("stall_valid", m, ov[m], 1'b1);
          chk("stall_any", m, oa[m], prev_any[m]);
        end
        chk("out_valid", m, ov[m], mv[m][lat(m)-1]);
        chk("out_any", m, oa[m], ma[m][lat(m)-1]);
        chk("out_zero", m, oz[m], !ma[m][lat(m)-1]);
        chk("in_ready", m, ir[m], m_in_ready(m));
        chk("sticky", m, st[m], ms[m]);
        if (ov[m] === 1'b1 && ordy[m]) begin
          $display("dut%0d cyc=%0d deliver any=%0d zero=%0d", m, cyc, oa[m], oz[m]);
          if (m == 0) begin
            logc0.push_back(cyc);
            loga0.push_back(oa[m]);
          end else begin
            logc1.push_back(cyc);
            loga1.push_back(oa[m]);
            logz1.push_back(oz[m]);
          end
          if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL order dut%0d cyc=%0d got=extra beat exp=no beat", m, cyc);
          end else if (m == 0) begin
            chk("order", m, oa[m], sb0.pop_front());
          end else begin
            chk("order", m, oa[m], sb1.pop_front());
          end
        end
        if (iv[m] && ir[m] === 1'b1) acc[m]++;
        prev_stall[m] = (ov[m] === 1'b1) && !ordy[m];
        prev_any[m] = oa[m];
        model_step(m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int base;
    int a;
    int n;
    logic [31:0] t3_data [5];
    bit t2_exp [4];
    t3_data = '{32'h1, 32'h0, 32'h4, 32'h2, 32'h8};
    t2_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    acc = '{0, 0};

    // Reset with junk inputs.
    iv = '{1'b1, 1'b1};
    ordy = '{1'b1, 1'b1};
    sclr = '{1'b1, 1'b1};
    d0 = 32'hdead_beef;
    d1 = 7'h55;
    repeat (3) @(posedge clk);
    #1;
    iv = '{1'b0, 1'b0};
    sclr = '{1'b0, 1'b0};
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 0, ir[0], 1'b1);
    chk("ready_after_rst", 1, ir[1], 1'b1);

    // Back-to-back stream, no stall.
    tick();
    c = cyc;
    base = logc0.size();
    iv[0] = 1'b1;
    d0 = 32'h0;           tick();
    d0 = 32'h8000_0000;   tick();
    d0 = 32'h1;           tick();
    d0 = 32'h0;           tick();
    iv[0] = 1'b0;
    repeat (6) tick();
    chk("t2_count", 0, logc0.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < logc0.size()) begin
        chk("t2_cycle", 0, logc0[base+i], c + 3 + i);
        chk("t2_any", 0, loga0[base+i], t2_exp[i]);
      end
    end
    chk("t2_sticky", 0, st[0], 1'b1);

    // Backpressure: three accepts fill the pipe.
    ordy[0] = 1'b0;
    a = acc[0];
    base = logc0.size();
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d0 = t3_data[i];
      tick();
    end
    iv[0] = 1'b0;
    tick();
    chk("t3_accepts", 0, acc[0] - a, 3);
    chk("t3_full_ready", 0, ir[0], 1'b0);
    ordy[0] = 1'b1;
    repeat (6) tick();
    chk("t3_count", 0, logc0.size() - base, 3);
    if (logc0.size() - base == 3) begin
      chk("t3_any0", 0, loga0[base], 1'b1);
      chk("t3_any1", 0, loga0[base+1], 1'b0);
      chk("t3_any2", 0, loga0[base+2], 1'b1);
    end

    // Sticky clear without delivery, then clear coinciding with deliveries.
    sclr[0] = 1'b1;
    tick();
    sclr[0] = 1'b0;
    chk("t4_clear_idle", 0, st[0], 1'b0);
    for (int r = 0; r < 2; r++) begin
      ordy[0] = 1'b0;
      iv[0] = 1'b1;
      d0 = (r == 0) ? 32'h10 : 32'h0;
      tick();
      iv[0] = 1'b0;
      n = 0;
      while (ov[0] !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      chk("t4_wait_valid", 0, ov[0], 1'b1);
      sclr[0] = 1'b1;
      ordy[0] = 1'b1;
      tick();
      sclr[0] = 1'b0;
      chk("t4_clear_deliver", 0, st[0], (r == 0) ? 1'b1 : 1'b0);
    end

    // Reset with two beats in flight.
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    d0 = 32'h3;
    tick();
    d0 = 32'h0;
    tick();
    iv[0] = 1'b0;
    repeat (2) tick();
    chk("t5_inflight", 0, ov[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 0, ov[0], 1'b0);
    chk("t5_async_zero", 0, oz[0], 1'b1);
    tick();
    rst_n = 1'b1;
    base = logc0.size();
    ordy[0] = 1'b1;
    repeat (8) tick();
    chk("t5_no_stale", 0, logc0.size() - base, 0);

    // Odd width: walking one, then all-zero.
    ordy[1] = 1'b1;
    base = logc1.size();
    iv[1] = 1'b1;
    for (int b = 0; b < 7; b++) begin
      d1 = 7'd1 << b;
      tick();
    end
    d1 = 7'd0;
    tick();
    iv[1] = 1'b0;
    repeat (6) tick();
    chk("t6_count", 1, logc1.size() - base, 8);
    if (logc1.size() - base == 8) begin
      for (int b = 0; b < 7; b++) chk("t6_walk_any", 1, loga1[base+b], 1'b1);
      chk("t6_zero_any", 1, loga1[base+7], 1'b0);
      chk("t6_zero_flag", 1, logz1[base+7], 1'b1);
    end

    // Randomised traffic on both DUTs.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        iv[m] = ($urandom_range(0, 3) != 0);
        ordy[m] = ($urandom_range(0, 3) != 0);
        sclr[m] = ($urandom_range(0, 15) == 0);
      end
      case ($urandom_range(0, 2))
        0: d0 = 32'h0;
        1: d0 = 32'h1 << $urandom_range(0, 31);
        default: d0 = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0: d1 = 7'h0;
        1: d1 = 7'h1 << $urandom_range(0, 6);
        default: d1 = 7'($urandom);
      endcase
      tick();
    end
    iv = '{1'b0, 1'b0};
    ordy = '{1'b1, 1'b1};
    sclr = '{1'b0, 1'b0};
    repeat (8) tick();
    chk("drain_sb", 0, sb0.size(), 0);
    chk("drain_sb", 1, sb1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
